// File: rtl/axi_lite_cmd_master_pkg.sv
// Shared types and constants for the AXI4-Lite command master.
package axil_cmd_pkg;

  localparam int CMD_ADDR_W = 32;
  localparam int CMD_DATA_W = 32;
  localparam int CMD_STRB_W = CMD_DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR_AW_W,
    WR_B,
    RD_AR,
    RD_R,
    RSP
  } state_t;

  typedef struct packed {
    logic                  write;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
    logic [CMD_STRB_W-1:0] wstrb;
  } cmd_t;

endpackage

// File: rtl/axi_lite_cmd_master_if.sv
// AXI4-Lite bus bundle between the command master and a register-file slave.
interface axi_lite_cmd_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]              AWPROT;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]              ARPROT;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    output ARADDR, ARPROT, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    input  ARADDR, ARPROT, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

endinterface

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: turns one {write, addr, wdata, wstrb}
// command at a time into a bus transaction and returns {rdata, resp}.
module axi_lite_cmd_master
  import axil_cmd_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  axi_lite_cmd_master_if.master           M_AXI
);

  state_t                          state;
  state_t                          next_state;
  cmd_t                            cmd_q;
  logic                            aw_done;
  logic                            w_done;
  logic [C_M_AXI_DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]                      resp_q;
  logic                            cmd_ready_q;

  logic                            aw_valid;
  logic                            w_valid;
  logic                            cmd_hs;
  logic                            aw_hs;
  logic                            w_hs;
  logic                            misaligned;

  assign cmd_hs     = cmd_valid && cmd_ready_q;
  assign misaligned = (cmd_addr[1:0] != 2'b00);

  // AW and W each retire on their own handshake, in any order.
  assign aw_valid = (state == WR_AW_W) && !aw_done;
  assign w_valid  = (state == WR_AW_W) && !w_done;
  assign aw_hs    = aw_valid && M_AXI.AWREADY;
  assign w_hs     = w_valid && M_AXI.WREADY;

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (cmd_hs) begin
          if (misaligned)     next_state = RSP;
          else if (cmd_write) next_state = WR_AW_W;
          else                next_state = RD_AR;
        end
      end
      WR_AW_W: begin
        if ((aw_done || aw_hs) && (w_done || w_hs)) next_state = WR_B;
      end
      WR_B: begin
        if (M_AXI.BVALID) next_state = RSP;
      end
      RD_AR: begin
        if (M_AXI.ARREADY) next_state = RD_R;
      end
      RD_R: begin
        if (M_AXI.RVALID) next_state = RSP;
      end
      RSP: begin
        if (rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // cmd_ready is registered so it stays low throughout reset and never
  // depends combinationally on any input.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state       <= IDLE;
      cmd_q       <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      rdata_q     <= '0;
      resp_q      <= RESP_OKAY;
      cmd_ready_q <= 1'b0;
    end else begin
      state       <= next_state;
      cmd_ready_q <= (next_state == IDLE);
      case (state)
        IDLE: begin
          if (cmd_hs) begin
            cmd_q.write <= cmd_write;
            cmd_q.addr  <= cmd_addr;
            cmd_q.wdata <= cmd_wdata;
            cmd_q.wstrb <= cmd_wstrb;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            rdata_q     <= '0;
            resp_q      <= misaligned ? RESP_SLVERR : RESP_OKAY;
          end
        end
        WR_AW_W: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
        end
        WR_B: begin
          if (M_AXI.BVALID) resp_q <= M_AXI.BRESP;
        end
        RD_R: begin
          if (M_AXI.RVALID) begin
            rdata_q <= M_AXI.RDATA;
            resp_q  <= M_AXI.RRESP;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = (state == RSP);
  assign rsp_rdata = cmd_q.write ? '0 : rdata_q;
  assign rsp_resp  = resp_q;

  assign M_AXI.AWADDR  = cmd_q.addr;
  assign M_AXI.AWPROT  = 3'b000;
  assign M_AXI.AWVALID = aw_valid;
  assign M_AXI.WDATA   = cmd_q.wdata;
  assign M_AXI.WSTRB   = cmd_q.wstrb;
  assign M_AXI.WVALID  = w_valid;
  assign M_AXI.BREADY  = (state == WR_B);
  assign M_AXI.ARADDR  = cmd_q.addr;
  assign M_AXI.ARPROT  = 3'b000;
  assign M_AXI.ARVALID = (state == RD_AR);
  assign M_AXI.RREADY  = (state == RD_R);

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master: behavioural register-file slave with
// programmable ready delays, scoreboard of expected responses, protocol monitor.
module tb_axi_lite_cmd_master;
  import axil_cmd_pkg::*;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;

  logic        tb_ACLK = 1'b0;
  logic        tb_ARESETN;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;

  logic        fixed_rdy;
  logic        rand_rdy;
  logic        rand_bit = 1'b1;

  int checks = 0;
  int passes = 0;
  int cycle = 0;

  exp_t        sb[$];
  logic [31:0] model_mem [64];
  logic [31:0] pat [4] = '{32'h0101FFFF, 32'hABCD0001, 32'hDEAD0011, 32'hBEEF0011};

  always #5 tb_ACLK = ~tb_ACLK;
  always @(posedge tb_ACLK) cycle <= cycle + 1;

  axi_lite_cmd_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_axi ();

  axi_lite_cmd_master #(
    .C_M_AXI_ADDR_WIDTH(32),
    .C_M_AXI_DATA_WIDTH(32)
  ) dut (
    .ACLK      (tb_ACLK),
    .ARESETN   (tb_ARESETN),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_wstrb (cmd_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_resp  (rsp_resp),
    .M_AXI     (m_axi)
  );

  assign rsp_ready = rand_rdy ? rand_bit : fixed_rdy;

  always @(posedge tb_ACLK) begin
    #1;
    rand_bit = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: 64 word registers at 0x00-0xFF; words 48-63 answer SLVERR,
  // misaligned commands answer SLVERR without touching the bus.
  function automatic exp_t model(input bit w, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] s);
    exp_t e;
    e.rdata = 32'h0;
    if (a[1:0] != 2'b00 || a[7:6] == 2'b11) begin
      e.resp = RESP_SLVERR;
    end else begin
      e.resp = RESP_OKAY;
      if (w) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) model_mem[a[7:2]][8*b +: 8] = d[8*b +: 8];
      end else begin
        e.rdata = model_mem[a[7:2]];
      end
    end
    return e;
  endfunction

  // Behavioural register-file slave with per-channel ready delays.
  int aw_delay = 0, w_delay = 0, ar_delay = 0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
  int b_count = 0;
  logic        aw_got, w_got;
  logic [31:0] aw_addr_s, w_data_s;
  logic [3:0]  w_strb_s;
  logic [31:0] slave_mem [64];

  assign m_axi.AWREADY = m_axi.AWVALID && (aw_cnt >= aw_delay);
  assign m_axi.WREADY  = m_axi.WVALID && (w_cnt >= w_delay);
  assign m_axi.ARREADY = m_axi.ARVALID && (ar_cnt >= ar_delay);

  always @(posedge tb_ACLK) begin : slave_model
    logic [31:0] wa, wd;
    logic [3:0]  ws;
    logic        aw_hs, w_hs;
    if (!tb_ARESETN) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0;
      m_axi.BVALID <= 1'b0; m_axi.BRESP <= 2'b00;
      m_axi.RVALID <= 1'b0; m_axi.RRESP <= 2'b00; m_axi.RDATA <= 32'h0;
      for (int i = 0; i < 64; i++) slave_mem[i] <= 32'h0;
    end else begin
      aw_hs = m_axi.AWVALID && m_axi.AWREADY;
      w_hs  = m_axi.WVALID && m_axi.WREADY;
      aw_cnt <= (m_axi.AWVALID && !m_axi.AWREADY) ? aw_cnt + 1 : 0;
      w_cnt  <= (m_axi.WVALID && !m_axi.WREADY) ? w_cnt + 1 : 0;
      ar_cnt <= (m_axi.ARVALID && !m_axi.ARREADY) ? ar_cnt + 1 : 0;
      wa = aw_hs ? m_axi.AWADDR : aw_addr_s;
      wd = w_hs ? m_axi.WDATA : w_data_s;
      ws = w_hs ? m_axi.WSTRB : w_strb_s;
      if (aw_hs) begin aw_got <= 1'b1; aw_addr_s <= m_axi.AWADDR; end
      if (w_hs) begin w_got <= 1'b1; w_data_s <= m_axi.WDATA; w_strb_s <= m_axi.WSTRB; end
      if (m_axi.BVALID && m_axi.BREADY) begin
        m_axi.BVALID <= 1'b0;
        b_count <= b_count + 1;
      end
      if ((aw_got || aw_hs) && (w_got || w_hs) && !m_axi.BVALID) begin
        aw_got <= 1'b0; w_got <= 1'b0;
        m_axi.BVALID <= 1'b1;
        if (wa[7:6] == 2'b11) begin
          m_axi.BRESP <= RESP_SLVERR;
        end else begin
          m_axi.BRESP <= RESP_OKAY;
          for (int b = 0; b < 4; b++)
            if (ws[b]) slave_mem[wa[7:2]][8*b +: 8] <= wd[8*b +: 8];
        end
      end
      if (m_axi.RVALID && m_axi.RREADY) m_axi.RVALID <= 1'b0;
      if (m_axi.ARVALID && m_axi.ARREADY) begin
        m_axi.RVALID <= 1'b1;
        m_axi.RRESP  <= (m_axi.ARADDR[7:6] == 2'b11) ? RESP_SLVERR : RESP_OKAY;
        m_axi.RDATA  <= (m_axi.ARADDR[7:6] == 2'b11) ? 32'h0 : slave_mem[m_axi.ARADDR[7:2]];
      end
    end
  end

  // Monitor: scoreboard pops on each rsp handshake, plus VALID/hold rules.
  logic        prev_aw_pend = 1'b0, prev_w_pend = 1'b0, prev_ar_pend = 1'b0, prev_rsp_pend = 1'b0;
  logic [31:0] prev_awaddr, prev_wdata, prev_araddr, prev_rsp_rdata;
  logic [3:0]  prev_wstrb;
  logic [1:0]  prev_rsp_resp;
  int aw_alone = 0, w_alone = 0, bus_cycles = 0;

  always @(negedge tb_ACLK) begin
    exp_t e;
    if (!tb_ARESETN) begin
      prev_aw_pend = 1'b0; prev_w_pend = 1'b0; prev_ar_pend = 1'b0; prev_rsp_pend = 1'b0;
    end else begin
      if (prev_aw_pend) check("awvalid_hold", {m_axi.AWVALID, m_axi.AWADDR}, {1'b1, prev_awaddr});
      if (prev_w_pend)
        check("wvalid_hold", {m_axi.WVALID, m_axi.WSTRB, m_axi.WDATA}, {1'b1, prev_wstrb, prev_wdata});
      if (prev_ar_pend) check("arvalid_hold", {m_axi.ARVALID, m_axi.ARADDR}, {1'b1, prev_araddr});
      if (prev_rsp_pend)
        check("rsp_hold", {rsp_valid, rsp_resp, rsp_rdata}, {1'b1, prev_rsp_resp, prev_rsp_rdata});
      if (m_axi.AWVALID && !m_axi.WVALID) aw_alone++;
      if (m_axi.WVALID && !m_axi.AWVALID) w_alone++;
      if (m_axi.AWVALID || m_axi.ARVALID) bus_cycles++;
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_rsp: got rdata 0x%0h resp %0d, required no response",
                   rsp_rdata, rsp_resp);
        end else begin
          e = sb.pop_front();
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_resp", rsp_resp, e.resp);
        end
      end
      prev_aw_pend   = m_axi.AWVALID && !m_axi.AWREADY;
      prev_awaddr    = m_axi.AWADDR;
      prev_w_pend    = m_axi.WVALID && !m_axi.WREADY;
      prev_wdata     = m_axi.WDATA;
      prev_wstrb     = m_axi.WSTRB;
      prev_ar_pend   = m_axi.ARVALID && !m_axi.ARREADY;
      prev_araddr    = m_axi.ARADDR;
      prev_rsp_pend  = rsp_valid && !rsp_ready;
      prev_rsp_rdata = rsp_rdata;
      prev_rsp_resp  = rsp_resp;
    end
  end

  // Called at posedge+1; returns the cycle of the cmd handshake.
  task automatic applyStimulus(input bit w, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, output int hs_cycle);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    @(negedge tb_ACLK);
    while (!cmd_ready && n < 100) begin
      @(negedge tb_ACLK);
      n++;
    end
    hs_cycle = cycle;
    if (!cmd_ready) begin
      checks++;
      $display("[TB] FAIL cmd_handshake_timeout: got cmd_ready 0, required 1 within 100 cycles");
    end else begin
      sb.push_back(model(w, a, d, s));
    end
    @(posedge tb_ACLK); #1;
    cmd_valid = 1'b0;
  endtask

  // Waits for the response handshake; exp_lat < 0 skips the latency check.
  task automatic checkOutput(input int hs_cycle, input int exp_lat);
    int n;
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge tb_ACLK);
      n++;
    end
    if (!rsp_valid) begin
      checks++;
      $display("[TB] FAIL rsp_timeout: got rsp_valid 0, required 1 within 200 cycles");
    end else begin
      if (exp_lat >= 0) check("rsp_latency", 64'(cycle - hs_cycle), 64'(exp_lat));
      while (!(rsp_valid && rsp_ready) && n < 400) begin
        @(negedge tb_ACLK);
        n++;
      end
      @(posedge tb_ACLK); #1;
    end
  endtask

  initial begin
    int          hs, n, a0, w0, b0, bus0;
    bit          w;
    logic [31:0] a, d, held_rdata;
    logic [3:0]  s;
    logic [1:0]  held_resp;

    tb_ARESETN = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    fixed_rdy = 1'b1; rand_rdy = 1'b0;
    for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;

    repeat (3) @(posedge tb_ACLK);
    #1;
    check("reset_cmd_ready", cmd_ready, 0);
    check("reset_valids", {m_axi.AWVALID, m_axi.WVALID, m_axi.ARVALID, rsp_valid}, 0);
    check("reset_readies", {m_axi.BREADY, m_axi.RREADY}, 0);
    check("reset_rsp_data", {rsp_resp, rsp_rdata}, 0);
    tb_ARESETN = 1'b1;
    repeat (2) @(posedge tb_ACLK);
    #1;
    check("cmd_ready_after_reset", cmd_ready, 1);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'(i * 4), pat[i], 4'hF, hs);
      checkOutput(hs, 3);
      applyStimulus(1'b0, 32'(i * 4), 32'h0, 4'h0, hs);
      checkOutput(hs, 3);
    end

    for (int k = 0; k < 2; k++) begin
      aw_delay = (k == 0) ? 3 : 0;
      w_delay  = (k == 0) ? 0 : 3;
      a0 = aw_alone; w0 = w_alone; b0 = b_count;
      applyStimulus(1'b1, 32'(16 + 4 * k), $urandom, 4'hF, hs);
      checkOutput(hs, -1);
      check("wvalid_dropped_first", (aw_alone - a0) > 0, k == 0);
      check("awvalid_dropped_first", (w_alone - w0) > 0, k == 1);
      check("single_b_handshake", 64'(b_count - b0), 1);
    end
    aw_delay = 0; w_delay = 0;

    applyStimulus(1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, hs); checkOutput(hs, 3);
    applyStimulus(1'b1, 32'h20, 32'h12345678, 4'h3, hs); checkOutput(hs, 3);
    applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, hs);        checkOutput(hs, 3);

    bus0 = bus_cycles;
    applyStimulus(1'b1, 32'h2, 32'hCAFEF00D, 4'hF, hs); checkOutput(hs, 1);
    applyStimulus(1'b0, 32'h6, 32'h0, 4'h0, hs);        checkOutput(hs, 1);
    check("misaligned_no_bus", 64'(bus_cycles - bus0), 0);

    fixed_rdy = 1'b0;
    applyStimulus(1'b0, 32'h4, 32'h0, 4'h0, hs);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge tb_ACLK);
      n++;
    end
    check("bp_rsp_valid", rsp_valid, 1);
    held_rdata = rsp_rdata; held_resp = rsp_resp;
    check("bp_rdata", held_rdata, 32'hABCD0001);
    for (int c = 0; c < 10; c++) begin
      @(negedge tb_ACLK);
      check("bp_stable", {rsp_valid, rsp_resp, rsp_rdata}, {1'b1, held_resp, held_rdata});
      check("bp_cmd_ready", cmd_ready, 0);
    end
    @(posedge tb_ACLK); #1;
    fixed_rdy = 1'b1;
    @(negedge tb_ACLK);
    check("bp_cmd_ready_at_hs", cmd_ready, 0);
    @(posedge tb_ACLK); #1;
    check("bp_cmd_ready_after_hs", cmd_ready, 1);
    check("bp_rsp_valid_after_hs", rsp_valid, 0);

    ar_delay = 5;
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, hs);
    n = 0;
    while (!m_axi.ARVALID && n < 20) begin
      @(negedge tb_ACLK);
      n++;
    end
    check("arvalid_before_reset", m_axi.ARVALID, 1);
    @(posedge tb_ACLK); #1;
    tb_ARESETN = 1'b0;
    @(posedge tb_ACLK); #1;
    check("midreset_valids", {m_axi.AWVALID, m_axi.WVALID, m_axi.ARVALID, rsp_valid}, 0);
    check("midreset_cmd_ready", cmd_ready, 0);
    sb.delete();
    for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;
    ar_delay = 0;
    @(posedge tb_ACLK); #1;
    tb_ARESETN = 1'b1;
    repeat (2) @(posedge tb_ACLK);
    #1;
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, hs);
    checkOutput(hs, 3);

    rand_rdy = 1'b1;
    for (int t = 0; t < 150; t++) begin
      aw_delay = $urandom_range(0, 3);
      w_delay  = $urandom_range(0, 3);
      ar_delay = $urandom_range(0, 3);
      w = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      applyStimulus(w, a, d, s, hs);
      checkOutput(hs, -1);
    end
    rand_rdy = 1'b0;
    aw_delay = 0; w_delay = 0; ar_delay = 0;
    @(posedge tb_ACLK); #1;
    check("scoreboard_drained", 64'(sb.size()), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
